// File: rtl/painter_pkg.sv
// Shared definitions for the painter engines and the VRAM write arbiter:
// arbiter state encodings, palette constants and the memory address width.
package painter_pkg;

  localparam int MEMORY_SIZE_BITS = 14;

  localparam logic [2:0] COLOR_BLACK  = 3'b000;
  localparam logic [2:0] COLOR_BLUE   = 3'b001;
  localparam logic [2:0] COLOR_YELLOW = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANTED = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: starting at ptr and wrapping modulo
// N_REQ, the first requester with req high wins (one-hot) and valid is set.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin owner of the single VRAM write port shared by the painter engines.
// Optional VRAM_ARB_TIMEOUT_EN revokes a grant after MAX_BURST cycles when others wait.
module vram_write_arbiter
  import painter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = MEMORY_SIZE_BITS,
  parameter int COLOR_W   = 3,
  parameter int MAX_BURST = 1024
) (
  input  logic                       Clck,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           we_in,
  input  logic [N_REQ*ADDR_W-1:0]    addr_in,
  input  logic [N_REQ*COLOR_W-1:0]   color_in,
  output logic [N_REQ-1:0]           grant,
  output logic [ADDR_W-1:0]          address,
  output logic [COLOR_W-1:0]         color,
  output logic                       print_enable,
  output logic                       busy,
  output arb_state_t                 state_dbg
);

  // Handshake: req is a level held for a whole job; grant stays with that
  // engine until its req is sampled low, then one dead cycle precedes the next grant.
  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] g_idx;
  logic [N_REQ-1:0] win_onehot;
  logic             win_valid;
  logic             revoke;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (win_onehot),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    g_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) win_idx = PTR_W'(i);
      if (grant[i])      g_idx   = PTR_W'(i);
    end
    next_ptr = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PTR_W'(1);
  end

`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  logic [CNT_W-1:0] burst_cnt;
  // Only cut a job short when someone else is actually waiting.
  assign revoke = (int'(burst_cnt) == MAX_BURST - 1) && (|(req & ~grant));
`else
  assign revoke = 1'b0;
`endif

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state        <= IDLE;
      ptr          <= '0;
      grant        <= '0;
      address      <= '0;
      color        <= '0;
      print_enable <= 1'b0;
`ifdef VRAM_ARB_TIMEOUT_EN
      burst_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE, RELEASE: begin
          print_enable <= 1'b0;
          if (win_valid) begin
            grant <= win_onehot;
            ptr   <= next_ptr;
            state <= GRANTED;
`ifdef VRAM_ARB_TIMEOUT_EN
            burst_cnt <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANTED: begin
          if (!req[g_idx] || revoke) begin
            grant        <= '0;
            print_enable <= 1'b0;
            state        <= RELEASE;
          end else begin
            address      <= addr_in[int'(g_idx)*ADDR_W +: ADDR_W];
            color        <= color_in[int'(g_idx)*COLOR_W +: COLOR_W];
            print_enable <= we_in[g_idx];
`ifdef VRAM_ARB_TIMEOUT_EN
            if (int'(burst_cnt) < MAX_BURST - 1) burst_cnt <= burst_cnt + CNT_W'(1);
`endif
          end
        end
        default: begin
          state        <= IDLE;
          grant        <= '0;
          print_enable <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state == GRANTED);
  assign state_dbg = state;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: directed job sequences, a per-cycle reference
// model of the round-robin port ownership, and literal checks of key events.
module tb_vram_write_arbiter;
  import painter_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 14;
  localparam int CW   = 3;
  localparam int MAXB = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      we_in;
  logic [N*AW-1:0]   addr_in;
  logic [N*CW-1:0]   color_in;
  logic [N-1:0]      grant;
  logic [AW-1:0]     address;
  logic [CW-1:0]     color;
  logic              print_enable;
  logic              busy;
  arb_state_t        state_dbg;

  int total = 0;
  int bad   = 0;

  vram_write_arbiter #(
    .N_REQ     (N),
    .ADDR_W    (AW),
    .COLOR_W   (CW),
    .MAX_BURST (MAXB)
  ) dut (
    .Clck         (clk),
    .Reset        (rst_n),
    .req          (req),
    .we_in        (we_in),
    .addr_in      (addr_in),
    .color_in     (color_in),
    .grant        (grant),
    .address      (address),
    .color        (color),
    .print_enable (print_enable),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // reference model: who owns the port, where the rotation resumes, what was written
  int          m_own   = -1;
  int          m_next  = 0;
  int          m_burst = 0;
  bit          m_gap   = 1'b0;
  bit          m_pe    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [CW-1:0] m_color = '0;
  bit          m_on    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (from + i) % N;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic bit has(input logic [N-1:0] r, input int j);
    return ((r >> j) & 4'd1) != 4'd0;
  endfunction

  function automatic bit timeout_hit(input logic [N-1:0] r, input int own, input int burst);
`ifdef VRAM_ARB_TIMEOUT_EN
    return (burst == MAXB - 1) && ((r & ~(4'd1 << own)) != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    m_on <= 1'b1;
    if (!rst_n) begin
      m_own <= -1; m_next <= 0; m_gap <= 1'b0; m_pe <= 1'b0;
      m_addr <= '0; m_color <= '0; m_burst <= 0;
    end else if (m_own >= 0) begin
      if (!has(req, m_own) || timeout_hit(req, m_own, m_burst)) begin
        m_own <= -1; m_gap <= 1'b1; m_pe <= 1'b0;
      end else begin
        m_addr  <= AW'(addr_in >> (m_own * AW));
        m_color <= CW'(color_in >> (m_own * CW));
        m_pe    <= has(we_in, m_own);
        if (m_burst < MAXB - 1) m_burst <= m_burst + 1;
      end
    end else begin
      m_gap <= 1'b0;
      m_pe  <= 1'b0;
      if (pick(req, m_next) >= 0) begin
        m_own   <= pick(req, m_next);
        m_next  <= (pick(req, m_next) + 1) % N;
        m_burst <= 0;
      end
    end
  end

  // scoreboard: every cycle the registered outputs must match the model
  always @(negedge clk) begin
    if (m_on) begin
      chk("grant", 32'(grant), (m_own >= 0) ? 32'(1 << m_own) : 32'd0);
      chk("address", 32'(address), 32'(m_addr));
      chk("color", 32'(color), 32'(m_color));
      chk("print_enable", 32'(print_enable), 32'(m_pe));
      chk("busy", 32'(busy), 32'(m_own >= 0));
      chk("state", 32'(state_dbg),
          (m_own >= 0) ? 32'(GRANTED) : (m_gap ? 32'(RELEASE) : 32'(IDLE)));
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int i, input int v);
    addr_in[i*AW +: AW] = AW'(v);
  endtask

  task automatic set_color(input int i, input logic [CW-1:0] v);
    color_in[i*CW +: CW] = v;
  endtask

  int seen [4];
  int gaps [3];
  int hold [N];
  int nseen;
  int zr;
  int n0;
  logic [N-1:0] prev;
  logic [N-1:0] rr_mask;

  initial begin
    rst_n = 1'b0; req = '0; we_in = '0; addr_in = '0; color_in = '0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_color", 32'(color), 32'd0);
      chk("rst_pe", 32'(print_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'b0001);
    req = '0;
    cyc(2);

    // single engine write
    req = 4'b0010; we_in = 4'b0010; set_addr(1, 100); set_color(1, 3'b110);
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'b0010);
    @(negedge clk);
    chk("single_address", 32'(address), 32'd100);
    chk("single_color", 32'(color), 32'b110);
    chk("single_pe", 32'(print_enable), 32'd1);
    req = '0; we_in = '0;
    cyc(2);

    // round robin over engines 0,1,3 holding each job for five cycles
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rr_mask = 4'b1011; req = rr_mask;
    foreach (seen[i]) seen[i] = -1;
    foreach (gaps[i]) gaps[i] = -1;
    foreach (hold[i]) hold[i] = 0;
    nseen = 0; zr = 0; prev = '0;
    for (int c = 0; c < 80 && nseen < 4; c++) begin
      @(negedge clk);
      if (grant != '0) begin
        if (grant != prev) begin
          if (nseen > 0) gaps[nseen-1] = zr;
          for (int i = 0; i < N; i++) if (grant[i]) seen[nseen] = i;
          nseen++;
        end
        zr = 0;
      end else begin
        zr++;
      end
      prev = grant;
      for (int i = 0; i < N; i++) begin
        if (rr_mask[i]) begin
          if (grant[i]) begin
            hold[i]++;
            if (hold[i] == 5) begin req[i] = 1'b0; hold[i] = 0; end
          end else begin
            req[i] = 1'b1;
          end
        end
      end
    end
    chk("rr_count", 32'(nseen), 32'd4);
    chk("rr_order0", 32'(seen[0]), 32'd0);
    chk("rr_order1", 32'(seen[1]), 32'd1);
    chk("rr_order2", 32'(seen[2]), 32'd3);
    chk("rr_order3", 32'(seen[3]), 32'd0);
    for (int i = 0; i < 3; i++) chk("rr_gap", 32'(gaps[i]), 32'd1);
    req = '0;
    cyc(3);

    // isolation: engine 2 owns the port while engine 0 drives a write
    req = 4'b0101; we_in = 4'b0001;
    set_addr(0, 7); set_color(0, COLOR_YELLOW);
    set_addr(2, 55); set_color(2, COLOR_BLUE);
    @(negedge clk);
    chk("iso_grant", 32'(grant), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("iso_pe", 32'(print_enable), 32'd0);
      chk("iso_addr_is_7", 32'(address == 14'd7), 32'd0);
    end
    chk("iso_address", 32'(address), 32'd55);
    req[2] = 1'b0;
    cyc(4);
    req = '0; we_in = '0;
    cyc(3);

    // reset in the middle of a writing job
    req = 4'b0010; we_in = 4'b0010; set_addr(1, 300); set_color(1, COLOR_YELLOW);
    cyc(2);
    chk("mid_pe_before", 32'(print_enable), 32'd1);
    chk("mid_address_before", 32'(address), 32'd300);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_pe", 32'(print_enable), 32'd0);
    rst_n = 1'b1; req = 4'b1111; we_in = '0;
    @(negedge clk);
    chk("mid_ptr_zero", 32'(grant), 32'b0001);
    chk("mid_no_write", 32'(print_enable), 32'd0);
    req = '0;
    cyc(3);

`ifdef VRAM_ARB_TIMEOUT_EN
    // timeout: engine 0 holds its job, engine 1 waits
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0001; we_in = 4'b0001;
    @(negedge clk);
    req[1] = 1'b1;
    n0 = 0;
    while (grant == 4'b0001 && n0 < 40) begin
      n0++;
      @(negedge clk);
    end
    chk("to_len", 32'(n0), 32'd8);
    chk("to_gap", 32'(grant), 32'd0);
    @(negedge clk);
    chk("to_next", 32'(grant), 32'b0010);
    cyc(2);
    req[1] = 1'b0;
    @(negedge clk);
    chk("to_gap2", 32'(grant), 32'd0);
    @(negedge clk);
    chk("to_regrant", 32'(grant), 32'b0001);
    req = '0; we_in = '0;
    cyc(3);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Shares the single video-memory write port among up to N_REQ drawing engines: board painter, chess painter, pointer painter and screen clear. Each engine raises a request for a whole drawing job. The arbiter grants one engine at a time in round-robin order and holds the grant until that engine drops its request. It registers the granted engine's address, color and write enable onto the memory port. It sits between the painter engines and the VGA adapter's write interface.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 14, video memory address width
- COLOR_W, 3, pixel color width
- MAX_BURST, 1024, grant-cycle limit; used only with VRAM_ARB_TIMEOUT_EN

Ports:
- Clck  in  1  clock, all state changes on rising edge
- Reset  in  1  reset; synchronous, active-low
- req  in  N_REQ  per-engine job request, level, held for the whole job
- we_in  in  N_REQ  per-engine pixel write strobe
- addr_in  in  N_REQ*ADDR_W  per-engine address; slice i = [i*ADDR_W +: ADDR_W]
- color_in  in  N_REQ*COLOR_W  per-engine color, same packing
- grant  out  N_REQ  one-hot grant, registered
- address  out  ADDR_W  memory write address, registered
- color  out  COLOR_W  memory write color, registered
- print_enable  out  1  memory write enable, registered
- busy  out  1  high while any grant is held

## Operation
- States: IDLE, GRANTED, RELEASE; 2-bit encoding.
- Round-robin pointer ptr is log2(N_REQ) bits. The search starts at ptr and wraps modulo N_REQ; the first requester found with req high wins.
- IDLE:
  - if any req is high, grant the winner, set ptr to (winner+1) mod N_REQ, go to GRANTED;
  - otherwise stay in IDLE.
- GRANTED:
  - each cycle, address, color and print_enable load from the granted slice: print_enable = we_in[g].
  - we_in, addr_in and color_in of non-granted engines are ignored.
  - When req[g] is sampled low: grant goes to 0, print_enable goes to 0, go to RELEASE.
- RELEASE: print_enable stays 0. Run the same search as IDLE. Go to GRANTED with the new winner if one exists, otherwise go to IDLE.
- A requester that drops req and re-raises it in the same RELEASE cycle competes normally. Because ptr has advanced past it, any other pending engine wins first.
- Grant is never given to an engine whose req is low. grant is one-hot or zero at all times.
- busy = (state == GRANTED).

## Timing
- Reset (Reset == 0 at a rising edge) forces:
  - state = IDLE, ptr = 0, grant = 0;
  - address = 0, color = 0, print_enable = 0, busy = 0.
- Reset mid-job drops the grant immediately at that edge. No write occurs in the following cycle.
- Request to grant: req sampled high at edge k in IDLE gives grant high after edge k.
- Write latency: we_in/addr_in/color_in sampled at edge k while granted appear on print_enable/address/color after edge k. That is one cycle of latency.
- Hand-over: req[g] sampled low at edge k gives grant = 0 after edge k. The next grant is high after edge k+1. The dead time is exactly one cycle with print_enable = 0.
- Engines must hold addr/color/we_in stable only while grant is high. An engine may assert we_in in the same cycle grant first rises.

## Configuration
- VRAM_ARB_TIMEOUT_EN defined:
  - a burst counter clears on each new grant and increments every GRANTED cycle.
  - When it reaches MAX_BURST-1 and another engine's req is high, the grant is revoked and the state goes to RELEASE, exactly as if req[g] had fallen.
  - The revoked engine keeps req high and is re-granted in its round-robin turn. It resumes its job from its own state.
- Not defined: no counter is built. A grant is held until req[g] falls, with no upper bound.

## Structure
- Shared package painter_pkg holds:
  - the arbiter state encodings;
  - the color constants (COLOR_BLACK, COLOR_BLUE, COLOR_YELLOW);
  - MEMORY_SIZE_BITS, which supplies the ADDR_W default.
- One sub-module, rr_priority_picker: combinational. Inputs are req and ptr. Outputs are a one-hot winner and a valid flag. It is used by both IDLE and RELEASE.

## Test plan
- Reset behaviour: hold Reset=0 for 3 cycles, then release. Required: grant=0, address=0, color=0, print_enable=0 and busy=0 throughout. The first grant after reset goes to engine 0 when req=4'b1111.
- Single engine: req=4'b0010, we_in[1]=1, addr_in slice 1 = 14'd100, color slice 1 = 3'b110. Required: grant=4'b0010 one cycle later, then address=100, color=3'b110, print_enable=1 one cycle after that.
- Round robin: req=4'b1011 held, each engine dropping req after 5 cycles. Required: grant order 0, 1, 3, 0, with exactly one zero-grant cycle between consecutive grants.
- Isolation: engine 2 granted with we_in[2]=0 while engine 0 drives we_in[0]=1, addr=14'd7. Required: print_enable stays 0 and address never equals 7.
- Reset mid-job: Reset=0 during GRANTED with print_enable=1. Required: after that edge grant=0, print_enable=0, and ptr=0.
- Timeout, with VRAM_ARB_TIMEOUT_EN and MAX_BURST=8: engine 0 holds req, engine 1 requests. Required: grant[0] drops after 8 cycles, grant[1] rises one cycle later, and engine 0 is re-granted after engine 1 drops req.
